// File: rtl/serial_word_collector.sv
// ============================================================================
// Module      : serial_word_collector
// Description : Serial-in/parallel-out receiver; collects DATA_SIZE LSB-first
//               bits per frame and presents the word on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_collector #(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 start,
    input  logic                 s_in,
    input  logic                 s_valid,
    output logic [DATA_SIZE-1:0] q,
    output logic                 q_valid,
    input  logic                 q_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] sreg;
    logic [CNT_W-1:0]     count;
    logic [DATA_SIZE-1:0] sreg_next;

    // New bit enters at the MSB so the first bit received ends up in bit 0.
    assign sreg_next = {s_in, sreg[DATA_SIZE-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            count   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        if (start) begin
                            state   <= SHIFT;
                            busy    <= 1'b1;
                            sreg    <= '0;
                            count   <= '0;
                            overrun <= 1'b0;
                        end else if (s_valid) begin
                            overrun <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (en && s_valid) begin
                        sreg <= sreg_next;
                        if (count == CNT_W'(DATA_SIZE - 1)) begin
                            q       <= sreg_next;
                            q_valid <= 1'b1;
                            busy    <= 1'b0;
                            count   <= '0;
                            state   <= DONE;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (en && s_valid) begin
                        overrun <= 1'b1;
                    end
                    // Handshake does not depend on en; start is ignored here.
                    if (q_ready) begin
                        q_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    q_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
